// File: rtl/dmem_lsu.sv
// Data memory with load/store unit front end for the MEM stage.
// Handles one access at a time with a valid/ready handshake and a configurable read latency.
module dmem_lsu #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-3:0] DEPTH_WORDS = (WIDTH-2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_next;
    logic [1:0]       cnt, cnt_next;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             illegal, misalign, fault;
    logic [AW-1:0]    word_idx;
    logic [WIDTH-1:0] rd_word, load_data, store_data, merged;
    logic [15:0]      half_lane;
    logic [7:0]       byte_lane;
    logic [3:0]       byte_en;

    assign req_ready = (state == IDLE) && !res;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[AW+1:2];
    assign rd_word   = mem[word_idx];
    assign fault     = illegal || misalign || (req_addr[WIDTH-1:2] >= DEPTH_WORDS);

    // Size/sign decode: stores only allow the three signed codes.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        case (req_funct3)
            3'b000:  misalign = 1'b0;
            3'b001:  misalign = req_addr[0];
            3'b010:  misalign = |req_addr[1:0];
            3'b100:  illegal  = req_we;
            3'b101: begin
                illegal  = req_we;
                misalign = req_addr[0];
            end
            default: illegal  = 1'b1;
        endcase
    end

    assign half_lane = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    assign byte_lane = req_addr[0] ? half_lane[15:8] : half_lane[7:0];

    always_comb begin
        load_data = '0;
        case (req_funct3)
            3'b000:  load_data = {{(WIDTH-8){byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{(WIDTH-16){half_lane[15]}}, half_lane};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {{(WIDTH-8){1'b0}}, byte_lane};
            3'b101:  load_data = {{(WIDTH-16){1'b0}}, half_lane};
            default: load_data = '0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en    = 4'b1111;
        store_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << req_addr[1:0];
                store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = req_wdata;
            end
        endcase
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = store_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) mem[word_idx] <= merged;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                rsp_fault <= fault;
                rsp_rdata <= (req_we || fault) ? '0 : load_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 2'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt == 2'd0) state_next = RESP;
                else             cnt_next   = cnt - 2'd1;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed cases plus randomized accesses
// compared against a byte-array reference memory.
module tb_dmem_lsu;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        res;
    logic        req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;

    int tests_run = 0;
    int failed    = 0;

    logic [7:0] model_mem [DEPTH*4];

    dmem_lsu #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    function automatic int access_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic exp_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        if ((int'(a[1:0]) % access_size(f3)) != 0) return 1'b1;
        if (int'(a >> 2) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = access_size(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[int'(a) + i];
        if (!f3[2] && n < 4 && v[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < access_size(f3); i++) model_mem[int'(a) + i] = wd[8*i +: 8];
    endtask

    // One complete transaction with rsp_ready held high; returns the response and its latency.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                          output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests_run++; failed++;
            $display("[TB] FAIL req_ready_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd  = rsp_rdata;
        flt = rsp_fault;
        @(posedge clk);
    endtask

    task automatic test_reset;
        res = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_fault !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_outputs: ready=%b valid=%b rdata=%h fault=%b required 0 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_fault);
        end
        res = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL reset_release_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic init_memory;
        logic [31:0] rd; logic flt; int lat;
        for (int w = 0; w < DEPTH; w++) begin
            access(1'b1, 3'b010, 32'(w*4), 32'd0, rd, flt, lat);
            model_store(3'b010, 32'(w*4), 32'd0);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic flt; int lat;
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, flt, lat);
        model_store(3'b010, 32'h10, 32'hDEADBEEF);
        access(1'b0, 3'b010, 32'h10, 32'd0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'hDEADBEEF || flt !== 1'b0 || lat != LAT) begin
            failed++;
            $display("[TB] FAIL word_rw: rdata=%h fault=%b lat=%0d required deadbeef 0 %0d", rd, flt, lat, LAT);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd; logic flt; int lat;
        logic [31:0] addrs [3];
        logic [2:0]  f3s [3];
        logic [31:0] exps [3];
        addrs = '{32'h20, 32'h21, 32'h21};
        f3s   = '{3'b010, 3'b000, 3'b100};
        exps  = '{32'h00008000, 32'hFFFFFF80, 32'h00000080};
        access(1'b1, 3'b000, 32'h21, 32'h00000080, rd, flt, lat);
        model_store(3'b000, 32'h21, 32'h80);
        for (int i = 0; i < 3; i++) begin
            access(1'b0, f3s[i], addrs[i], 32'd0, rd, flt, lat);
            tests_run++;
            if (rd !== exps[i] || flt !== 1'b0) begin
                failed++;
                $display("[TB] FAIL byte_lane_%0d: rdata=%h fault=%b required %h 0", i, rd, flt, exps[i]);
            end
        end
    endtask

    task automatic test_halfword;
        logic [31:0] rd; logic flt; int lat;
        access(1'b1, 3'b010, 32'h30, 32'h1234ABCD, rd, flt, lat);
        model_store(3'b010, 32'h30, 32'h1234ABCD);
        access(1'b1, 3'b001, 32'h32, 32'h00008001, rd, flt, lat);
        model_store(3'b001, 32'h32, 32'h8001);
        access(1'b0, 3'b001, 32'h32, 32'd0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'hFFFF8001) begin
            failed++; $display("[TB] FAIL lh: rdata=%h required ffff8001", rd);
        end
        access(1'b0, 3'b101, 32'h32, 32'd0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'h00008001) begin
            failed++; $display("[TB] FAIL lhu: rdata=%h required 00008001", rd);
        end
        access(1'b0, 3'b010, 32'h30, 32'd0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'h8001ABCD) begin
            failed++; $display("[TB] FAIL sh_preserve: rdata=%h required 8001abcd", rd);
        end
    endtask

    task automatic test_faults;
        logic [31:0] rd; logic flt; int lat;
        access(1'b0, 3'b010, 32'h13, 32'd0, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'd0) begin
            failed++; $display("[TB] FAIL lw_misaligned: fault=%b rdata=%h required 1 0", flt, rd);
        end
        access(1'b1, 3'b010, 32'h14, 32'hCAFEF00D, rd, flt, lat);
        model_store(3'b010, 32'h14, 32'hCAFEF00D);
        access(1'b1, 3'b001, 32'h15, 32'h00001111, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1) begin
            failed++; $display("[TB] FAIL sh_misaligned: fault=%b required 1", flt);
        end
        access(1'b0, 3'b010, 32'h14, 32'd0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'hCAFEF00D) begin
            failed++; $display("[TB] FAIL sh_fault_no_write: rdata=%h required cafef00d", rd);
        end
        access(1'b0, 3'b011, 32'h10, 32'd0, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'd0) begin
            failed++; $display("[TB] FAIL illegal_funct3: fault=%b rdata=%h required 1 0", flt, rd);
        end
        access(1'b0, 3'b010, 32'(DEPTH*4), 32'd0, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1) begin
            failed++; $display("[TB] FAIL out_of_range: fault=%b required 1", flt);
        end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != LAT || rsp_rdata !== 32'hDEADBEEF) begin
            failed++;
            $display("[TB] FAIL bp_first_resp: lat=%0d rdata=%h required %0d deadbeef", n, rsp_rdata, LAT);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_fault !== 1'b0 || req_ready !== 1'b0) begin
                failed++;
                $display("[TB] FAIL bp_hold_%0d: valid=%b rdata=%h fault=%b ready=%b required 1 deadbeef 0 0",
                         c, rsp_valid, rsp_rdata, rsp_fault, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL bp_release: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    // Reset lands while the access sits in WAIT; the response must never appear.
    task automatic test_reset_mid_wait(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic seen_valid;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = 3'b010; req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 res = 1'b1;
        seen_valid = rsp_valid;
        repeat (2) begin
            @(negedge clk);
            seen_valid = seen_valid | rsp_valid;
        end
        res = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen_valid = seen_valid | rsp_valid;
        end
        tests_run++;
        if (seen_valid !== 1'b0 || req_ready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL reset_mid_wait: saw_valid=%b ready=%b required 0 1", seen_valid, req_ready);
        end
    endtask

    task automatic test_reset_recovery;
        logic [31:0] rd; logic flt; int lat;
        test_reset_mid_wait(1'b0, 32'h10, 32'd0);
        access(1'b0, 3'b010, 32'h10, 32'd0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'hDEADBEEF || flt !== 1'b0 || lat != LAT) begin
            failed++;
            $display("[TB] FAIL after_reset_load: rdata=%h fault=%b lat=%0d required deadbeef 0 %0d", rd, flt, lat, LAT);
        end
        test_reset_mid_wait(1'b1, 32'h40, 32'h12345678);
        model_store(3'b010, 32'h40, 32'h12345678);
        access(1'b0, 3'b010, 32'h40, 32'd0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'h12345678) begin
            failed++; $display("[TB] FAIL store_survives_reset: rdata=%h required 12345678", rd);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, wd, exp_rd; logic flt, we, exp_flt; logic [2:0] f3; int lat;
        for (int k = 0; k < 200; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 + 15));
            wd = $urandom;
            exp_flt = exp_fault(we, f3, a);
            exp_rd  = (we || exp_flt) ? 32'd0 : exp_load(f3, a);
            access(we, f3, a, wd, rd, flt, lat);
            if (we && !exp_flt) model_store(f3, a, wd);
            tests_run++;
            if (rd !== exp_rd || flt !== exp_flt || lat != LAT) begin
                failed++;
                $display("[TB] FAIL random_%0d we=%b f3=%0d addr=%h: rdata=%h fault=%b lat=%0d required %h %b %0d",
                         k, we, f3, a, rd, flt, lat, exp_rd, exp_flt, LAT);
            end
        end
    endtask

    initial begin
        test_reset;
        init_memory;
        test_word;
        test_byte_lanes;
        test_halfword;
        test_faults;
        test_backpressure;
        test_reset_recovery;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
